// File: rtl/rx_engine.sv
`timescale 1ns/1ps
// UART 8N1 receive engine: synchronises the serial line, recovers LSB-first
// bytes by 3-sample mid-bit majority vote, and pushes each good byte as a one-cycle write.
module rx_engine #(
  parameter int OSR = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       osr_tick_i,
  input  logic       rx_en_i,
  input  logic       rx_data_i,
  output logic       rx_fifo_wen_o,
  output logic [7:0] rx_fifo_wdata_o,
  output logic       rx_frame_err_o,
  output logic       rx_break_o,
  output logic       rx_busy_o
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] T_S0   = TW'(OSR/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OSR/2);
  localparam logic [TW-1:0] T_VOTE = TW'(OSR/2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sync1, r_sync2;
  logic [TW-1:0]   r_tick_cnt, w_tick_nxt, w_tick_inc;
  logic [2:0]      r_bit_idx, w_bit_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic            r_s0, r_s1;
  logic            r_wen, w_wen_nxt;
  logic [7:0]      r_wdata, w_wdata_nxt;
  logic            r_ferr, w_ferr_nxt;
  logic            r_brk, w_brk_nxt;
  logic            w_rx_sync, w_vote, w_vote_pt, w_last;

  assign w_rx_sync  = r_sync2;
  assign w_vote     = (r_s0 & r_s1) | (r_s0 & w_rx_sync) | (r_s1 & w_rx_sync);
  assign w_vote_pt  = (r_tick_cnt == T_VOTE);
  assign w_last     = (r_tick_cnt == T_LAST);
  assign w_tick_inc = w_last ? '0 : r_tick_cnt + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // The synchroniser resets to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_wen      <= 1'b0;
      r_wdata    <= '0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
    end else begin
      r_sync1    <= rx_data_i;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_wen      <= w_wen_nxt;
      r_wdata    <= w_wdata_nxt;
      r_ferr     <= w_ferr_nxt;
      r_brk      <= w_brk_nxt;
      if (osr_tick_i && r_tick_cnt == T_S0) r_s0 <= w_rx_sync;
      if (osr_tick_i && r_tick_cnt == T_S1) r_s1 <= w_rx_sync;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_wdata_nxt = r_wdata;
    w_wen_nxt   = 1'b0;
    w_ferr_nxt  = 1'b0;
    w_brk_nxt   = 1'b0;

    if (!rx_en_i) begin
      // Disable beats a coincident tick; partial frame is dropped, last byte kept.
      w_state_nxt = S_IDLE;
      w_tick_nxt  = '0;
      w_bit_nxt   = '0;
      w_shift_nxt = '0;
    end else if (osr_tick_i) begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_rx_sync) begin
            w_state_nxt = S_START;
            w_tick_nxt  = TW'(1);
          end
        end
        S_START: begin
          w_tick_nxt = w_tick_inc;
          if (w_vote_pt && w_vote) begin
            w_state_nxt = S_IDLE;
            w_tick_nxt  = '0;
          end else if (w_last) begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = '0;
          end
        end
        S_DATA: begin
          w_tick_nxt = w_tick_inc;
          if (w_vote_pt) w_shift_nxt = {w_vote, r_shift[7:1]};
          if (w_last) begin
            if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
            else                   w_bit_nxt   = r_bit_idx + 3'd1;
          end
        end
        S_STOP: begin
          w_tick_nxt = w_tick_inc;
          if (w_vote_pt) begin
            w_tick_nxt = '0;
            if (w_vote) begin
              w_wdata_nxt = r_shift;
              w_wen_nxt   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_brk_nxt   = (r_shift == 8'h00);
              w_state_nxt = S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx_sync) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign rx_fifo_wen_o   = r_wen;
  assign rx_fifo_wdata_o = r_wdata;
  assign rx_frame_err_o  = r_ferr;
  assign rx_break_o      = r_brk;
  assign rx_busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rx_engine.sv
`timescale 1ns/1ps
// Directed bench for rx_engine: OSR=16, one tick every 4 clocks (64 clocks per bit).
module tb_rx_engine;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset, tick, rx_en, rx;
  logic       wen, ferr, brk, busy;
  logic [7:0] wdata;

  int         n_pass = 0;
  int         n_total = 0;
  int         wen_cnt = 0, ferr_cnt = 0, brk_cnt = 0;
  logic [7:0] q[$];

  rx_engine #(.OSR(16)) dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .osr_tick_i      (tick),
    .rx_en_i         (rx_en),
    .rx_data_i       (rx),
    .rx_fifo_wen_o   (wen),
    .rx_fifo_wdata_o (wdata),
    .rx_frame_err_o  (ferr),
    .rx_break_o      (brk),
    .rx_busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Tick generator: high for one clock in every four.
  initial begin
    int c;
    c = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (c == 3);
      c = (c + 1) % 4;
    end
  end

  // Pulse monitor: counts high cycles of each strobe, captures written bytes.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      wen_cnt++;
      q.push_back(wdata);
    end
    if (ferr === 1'b1) ferr_cnt++;
    if (brk === 1'b1)  brk_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  initial begin
    int w0, f0, b0, q0;
    logic [7:0] d;

    reset = 1'b1; rx_en = 1'b1; rx = 1'b1;
    wait_clks(4);
    chk("reset_wen",   wen,   1'b0);
    chk("reset_wdata", wdata, 8'h00);
    chk("reset_ferr",  ferr,  1'b0);
    chk("reset_brk",   brk,   1'b0);
    chk("reset_busy",  busy,  1'b0);
    reset = 1'b0;
    send_bit(1'b1);

    // Good frame 0xA5
    w0 = wen_cnt; f0 = ferr_cnt; q0 = q.size();
    d = 8'hA5;
    send_bit(1'b0);
    chk("good_busy_start", busy, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    rx = 1'b1;
    wait_clks(16);
    chk("good_busy_in_stop", busy, 1'b1);
    wait_clks(48);
    chk("good_busy_after_stop", busy, 1'b0);
    chk("good_wen_cnt", wen_cnt - w0, 1);
    chk("good_byte",    q[q0], 8'hA5);
    chk("good_wdata",   wdata, 8'hA5);
    chk("good_no_ferr", ferr_cnt - f0, 0);
    send_bit(1'b1);

    // Glitch on idle line: 4 ticks low
    w0 = wen_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    wait_clks(8);
    chk("glitch_busy_start", busy, 1'b1);
    wait_clks(8);
    rx = 1'b1;
    wait_clks(32);
    chk("glitch_busy_low", busy, 1'b0);
    chk("glitch_no_wen",   wen_cnt - w0, 0);
    chk("glitch_no_ferr",  ferr_cnt - f0, 0);
    send_bit(1'b1);

    // 0x3C with one mid-bit sample of bit 3 inverted
    w0 = wen_cnt; q0 = q.size();
    d = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    rx = 1'b1; wait_clks(30);
    rx = 1'b0; wait_clks(4);
    rx = 1'b1; wait_clks(30);
    for (int i = 4; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("spike_wen_cnt", wen_cnt - w0, 1);
    chk("spike_byte",    q[q0], 8'h3C);

    // Frame error: 0x3C with low stop bit
    w0 = wen_cnt; f0 = ferr_cnt; b0 = brk_cnt;
    send_frame(8'h3C, 1'b0);
    chk("ferr_busy_wait", busy, 1'b1);
    rx = 1'b1;
    wait_clks(8);
    chk("ferr_busy_exit", busy, 1'b0);
    chk("ferr_cnt",    ferr_cnt - f0, 1);
    chk("ferr_no_brk", brk_cnt - b0, 0);
    chk("ferr_no_wen", wen_cnt - w0, 0);
    send_bit(1'b1);

    // Break: 20 bit times low
    w0 = wen_cnt; f0 = ferr_cnt; b0 = brk_cnt;
    rx = 1'b0;
    wait_clks(20 * BIT_CLKS);
    chk("brk_busy_held", busy, 1'b1);
    rx = 1'b1;
    wait_clks(8);
    chk("brk_busy_exit", busy, 1'b0);
    chk("brk_ferr_cnt",  ferr_cnt - f0, 1);
    chk("brk_cnt",       brk_cnt - b0, 1);
    chk("brk_no_wen",    wen_cnt - w0, 0);
    send_bit(1'b1);

    // Abort: drop rx_en during bit 4 of 0x81
    w0 = wen_cnt; f0 = ferr_cnt; b0 = brk_cnt;
    d = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    wait_clks(32);
    chk("abort_busy_before", busy, 1'b1);
    rx_en = 1'b0;
    wait_clks(1);
    chk("abort_busy_next_clk", busy, 1'b0);
    wait_clks(31);
    for (int i = 5; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    send_bit(1'b1);
    rx_en = 1'b1;
    send_bit(1'b1);
    chk("abort_no_wen",   wen_cnt - w0, 0);
    chk("abort_no_ferr",  ferr_cnt - f0, 0);
    chk("abort_no_brk",   brk_cnt - b0, 0);
    chk("abort_wdata_kept", wdata, 8'h3C);

    // Reset mid-frame
    w0 = wen_cnt;
    send_bit(1'b0);
    send_bit(d[0]);
    send_bit(d[1]);
    reset = 1'b1;
    rx = 1'b1;
    wait_clks(1);
    chk("rst_busy",  busy,  1'b0);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_wen",   wen,   1'b0);
    chk("rst_ferr",  ferr,  1'b0);
    chk("rst_brk",   brk,   1'b0);
    reset = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    chk("rst_no_wen", wen_cnt - w0, 0);

    // Back-to-back frames, no idle gap
    w0 = wen_cnt; f0 = ferr_cnt; q0 = q.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    send_bit(1'b1);
    chk("b2b_wen_cnt", wen_cnt - w0, 3);
    chk("b2b_byte0",   q[q0],     8'h00);
    chk("b2b_byte1",   q[q0 + 1], 8'hFF);
    chk("b2b_byte2",   q[q0 + 2], 8'h55);
    chk("b2b_no_ferr", ferr_cnt - f0, 0);
    chk("b2b_wdata",   wdata, 8'h55);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rx_engine.md
Name: rx_engine

Overview:
UART receive engine: the receive-side counterpart of tx_engine, instantiated inside the uart_rx wrapper ahead of the RX uart_fifo. It synchronises the asynchronous serial line and detects start bits on the oversample tick. It recovers 8N1 frames, LSB first, using 3-sample majority voting at mid-bit. Each good byte is pushed to the RX FIFO as a single-cycle write; overrun is handled by the FIFO, and the engine never stalls.

Parameters:
OSR, 16, oversample ticks per bit; even, >= 8.

Ports:
clk_i  input  1  system clock
reset_i  input  1  synchronous, active-high reset
osr_tick_i  input  1  single-cycle pulse, OSR per bit period (from baud generator)
rx_en_i  input  1  receive enable
rx_data_i  input  1  asynchronous serial line, idle high
rx_fifo_wen_o  output  1  one-cycle write strobe to RX FIFO
rx_fifo_wdata_o  output  8  received byte
rx_frame_err_o  output  1  one-cycle pulse, stop bit sampled low
rx_break_o  output  1  one-cycle pulse, frame error with all-zero data
rx_busy_o  output  1  high whenever state != IDLE

Behaviour:
- One clock (clk_i); reset_i is synchronous and active-high.
- Reset values:
  - state = IDLE; synchroniser flops = 1.
  - Tick counter, bit index and shift register = 0.
  - All outputs = 0; rx_fifo_wdata_o = 0x00.
- Synchroniser: 2-flop, reset to 1; rx_sync is its output. All decisions use rx_sync only.
- Counters advance only on cycles with osr_tick_i = 1.
  - tick_cnt counts 0..OSR-1 within a bit period and wraps to 0.
  - bit_idx counts 0..7.
- Sampling:
  - Samples taken at tick_cnt = OSR/2-1, OSR/2 and OSR/2+1.
  - vote = majority of the three; it is evaluated on the tick where tick_cnt = OSR/2+1 (the "vote point").
- States:
  - IDLE:
    - On a tick with rx_en_i=1 and rx_sync=0: go to START, tick_cnt <= 1 (the detecting tick counts as tick 0).
  - START:
    - At the vote point, vote=1 is a false start: go to IDLE with no pulses.
    - Otherwise, on the tick at tick_cnt = OSR-1: go to DATA, bit_idx=0, tick_cnt=0.
  - DATA:
    - At the vote point, shift vote in at the MSB (shift right), so the first bit received ends up in bit 0.
    - On the tick at tick_cnt = OSR-1: if bit_idx=7 go to STOP, else increment bit_idx.
  - STOP, at the vote point:
    - vote=1: load rx_fifo_wdata_o with the shift register, pulse rx_fifo_wen_o, go to IDLE. Leaving at mid-stop allows resync to the next start edge.
    - vote=0: pulse rx_frame_err_o; also pulse rx_break_o if the shift register = 0x00. Go to WAIT_IDLE. No write.
  - WAIT_IDLE:
    - Stay until a tick with rx_sync=1, then go to IDLE. This prevents a held-low line from re-triggering.
- Latency: wen, frame_err and break assert in the clock cycle after the STOP vote-point tick, for exactly one cycle. rx_fifo_wdata_o changes only with wen and is held until the next write.
- rx_en_i:
  - rx_en_i=0 in any state forces IDLE at the next clock.
  - Partial data is discarded, with no pulses.
  - rx_fifo_wdata_o is retained.
- reset_i mid-frame returns everything to the reset values at the next clock, with no pulses.
- A tick arriving in the same cycle as the rx_en_i deassertion is ignored (disable wins).
- The engine has no backpressure input; a write into a full FIFO is reported as overrun by uart_fifo.

Test Plan:
- Good frame: OSR=16, tick every 4 clocks, rx_en_i=1, send 0xA5 8N1 -> one wen pulse, wdata=0xA5, busy high from start detect to mid-stop, no frame_err.
- Glitch rejection: 4-tick low pulse on an idle line -> START entered then IDLE, no wen/frame_err, busy low again within 9 ticks. Then invert a single sample (tick 8) of bit 3 during a 0x3C frame -> wdata=0x3C.
- Frame error: send 0x3C with stop bit low, then line high -> frame_err pulse once, no wen, no break, WAIT_IDLE exits on the first high tick.
- Break: hold line low for 20 bit times -> exactly one frame_err and one break pulse, busy held high until the line returns high, then IDLE, no wen.
- Abort and reset: drop rx_en_i during bit 4 of 0x81 -> IDLE next clock, no pulses, previous wdata kept. Repeat with reset_i mid-frame -> all outputs 0.
- Back-to-back: frames 0x00, 0xFF, 0x55 with no idle gap -> three wen pulses with the correct bytes in order, no errors.
